// File: rtl/cmlk_3d_repack_arbiter.sv
// Round-robin line arbiter feeding one 16-to-32-bit repacker.
// Grants whole lines per channel and zero-pads odd-length lines.
module cmlk_3d_repack_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1,
  parameter int LINE_WORDS = 640,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    src_req,
  input  logic [NUM_CH*16-1:0] src_din,
  input  logic [NUM_CH-1:0]    src_vld,
  output logic [NUM_CH-1:0]    src_gnt,
  output logic [15:0]          rp_din,
  output logic                 rp_din_vld,
  output logic [CH_W-1:0]      rp_ch,
  output logic                 line_done,
  output logic                 busy,
  output logic                 err_vld
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    PAD
  } state_t;

  localparam bit ODD = (LINE_WORDS % 2) == 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  sel;
  logic [CH_W-1:0]  idx;
  logic             hit;
  logic [15:0]      din_a [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_din
    assign din_a[i] = src_din[16*i +: 16];
  end

  // First requester after the last granted channel, with wrap.
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    hit = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!hit && src_req[idx]) begin
        sel = idx;
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_gnt    <= '0;
      rp_din     <= '0;
      rp_din_vld <= 1'b0;
      rp_ch      <= '0;
      line_done  <= 1'b0;
      busy       <= 1'b0;
      err_vld    <= 1'b0;
      cnt        <= '0;
      rr_ptr     <= CH_W'(NUM_CH - 1);
    end else begin
      rp_din_vld <= 1'b0;
      line_done  <= 1'b0;
      err_vld    <= |(src_vld & ~src_gnt);
      unique case (state)
        IDLE: begin
          if (hit) begin
            src_gnt <= NUM_CH'(1) << sel;
            rp_ch   <= sel;
            rr_ptr  <= sel;
            cnt     <= '0;
            state   <= BURST;
            busy    <= 1'b1;
          end
        end
        BURST: begin
          if (src_vld[rp_ch]) begin
            rp_din     <= din_a[rp_ch];
            rp_din_vld <= 1'b1;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST) begin
              src_gnt   <= '0;
              line_done <= !ODD;
              state     <= ODD ? PAD : IDLE;
              busy      <= ODD;
            end
          end
        end
        PAD: begin
          rp_din     <= '0;
          rp_din_vld <= 1'b1;
          line_done  <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmlk_3d_repack_arbiter.sv
// Scoreboard bench: even (4-word) and odd (3-word) line arbiters.
// Driver pushes expected repacker words, negedge monitors pop them.
module tb_cmlk_3d_repack_arbiter;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  ch;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  e_req, e_vld, e_gnt, o_req, o_vld, o_gnt;
  logic [31:0] e_din, o_din;
  logic [15:0] e_rp, o_rp;
  logic        e_rv, o_rv, e_ch, o_ch, e_ld, o_ld;
  logic        e_busy, o_busy, e_err, o_err;

  int checks = 0;
  int errors = 0;
  int e_errs = 0;
  int o_errs = 0;
  int n;
  exp_t eq_e[$];
  exp_t eq_o[$];
  exp_t ex_e, ex_o;

  cmlk_3d_repack_arbiter #(
    .NUM_CH(2), .CH_W(1), .LINE_WORDS(4), .CNT_W(16)
  ) u_even (
    .clk(clk), .rst_n(rst_n),
    .src_req(e_req), .src_din(e_din), .src_vld(e_vld),
    .src_gnt(e_gnt), .rp_din(e_rp), .rp_din_vld(e_rv),
    .rp_ch(e_ch), .line_done(e_ld), .busy(e_busy),
    .err_vld(e_err)
  );

  cmlk_3d_repack_arbiter #(
    .NUM_CH(2), .CH_W(1), .LINE_WORDS(3), .CNT_W(16)
  ) u_odd (
    .clk(clk), .rst_n(rst_n),
    .src_req(o_req), .src_din(o_din), .src_vld(o_vld),
    .src_gnt(o_gnt), .rp_din(o_rp), .rp_din_vld(o_rv),
    .rp_ch(o_ch), .line_done(o_ld), .busy(o_busy),
    .err_vld(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && e_rv) begin
      if (eq_e.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL even_unexpected_word: got %0h expected none", e_rp);
      end else begin
        ex_e = eq_e.pop_front();
        chk("even_data", e_rp, ex_e.d);
        chk("even_ch", e_ch, ex_e.ch);
        chk("even_done", e_ld, ex_e.done);
      end
    end
    if (rst_n && !e_rv) chk("even_done_alone", e_ld, 0);
    if (rst_n && e_err) e_errs++;
  end

  always @(negedge clk) begin
    if (rst_n && o_rv) begin
      if (eq_o.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL odd_unexpected_word: got %0h expected none", o_rp);
      end else begin
        ex_o = eq_o.pop_front();
        chk("odd_data", o_rp, ex_o.d);
        chk("odd_ch", o_ch, ex_o.ch);
        chk("odd_done", o_ld, ex_o.done);
      end
    end
    if (rst_n && !o_rv) chk("odd_done_alone", o_ld, 0);
    if (rst_n && o_err) o_errs++;
  end

  task automatic word(input bit odd, input int ch, input logic [15:0] d,
                      input bit last);
    if (!odd) begin
      e_din[16*ch +: 16] = d;
      e_vld[ch] = 1'b1;
      eq_e.push_back({d, 3'(ch), last});
    end else begin
      o_din[16*ch +: 16] = d;
      o_vld[ch] = 1'b1;
      eq_o.push_back({d, 3'(ch), 1'b0});
      if (last) eq_o.push_back({16'h0000, 3'(ch), 1'b1});
    end
    @(posedge clk);
    #1;
    e_vld = '0;
    o_vld = '0;
  endtask

  task automatic idle_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit odd, input logic [1:0] exp);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (odd && |o_gnt) break;
      if (!odd && |e_gnt) break;
    end
    if (odd) chk("odd_gnt", o_gnt, exp);
    else chk("even_gnt", e_gnt, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    e_req = '0; e_vld = '0; e_din = '0;
    o_req = '0; o_vld = '0; o_din = '0;
    #12;
    chk("rst_gnt", e_gnt, 0);
    chk("rst_rp_vld", e_rv, 0);
    chk("rst_rp_din", e_rp, 0);
    chk("rst_ch", e_ch, 0);
    chk("rst_busy", e_busy, 0);
    chk("rst_done", e_ld, 0);
    chk("rst_err", e_err, 0);
    chk("rst_odd_gnt", o_gnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single channel, even line
    e_req = 2'b01;
    wait_gnt(0, 2'b01);
    e_req = '0;
    chk("even_busy", e_busy, 1);
    for (int k = 1; k <= 4; k++) word(0, 0, 16'(k), k == 4);
    chk("even_gnt_clear", e_gnt, 0);
    chk("even_busy_end", e_busy, 0);

    // odd line gets a trailing zero pad
    o_req = 2'b10;
    wait_gnt(1, 2'b10);
    o_req = '0;
    word(1, 1, 16'h00A1, 0);
    word(1, 1, 16'h00A2, 0);
    word(1, 1, 16'h00A3, 1);
    chk("odd_gnt_clear", o_gnt, 0);
    chk("odd_busy_pad", o_busy, 1);
    idle_cyc();
    chk("odd_busy_end", o_busy, 0);
    chk("odd_ch_hold", o_ch, 1);

    // gaps in src_vld: 1,0,0,1,1,0,1
    e_req = 2'b01;
    wait_gnt(0, 2'b01);
    e_req = '0;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0 || i == 3 || i == 4 || i == 6) begin
        n++;
        word(0, 0, 16'(32'h0B00 + n), n == 4);
      end else begin
        idle_cyc();
      end
    end

    // ch1 valid while ch0 owns the grant
    e_req = 2'b01;
    wait_gnt(0, 2'b01);
    e_req = '0;
    word(0, 0, 16'h0C01, 0);
    e_din[31:16] = 16'hDEAD;
    e_vld[1] = 1'b1;
    word(0, 0, 16'h0C02, 0);
    e_vld[1] = 1'b1;
    word(0, 0, 16'h0C03, 0);
    word(0, 0, 16'h0C04, 1);

    // rotation from reset with both requests held
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    e_req = 2'b11;
    for (int l = 0; l < 4; l++) begin
      wait_gnt(0, (l % 2) ? 2'b10 : 2'b01);
      for (int k = 0; k < 4; k++)
        word(0, l % 2, 16'(32'h5000 + l * 16 + k), k == 3);
      if (l == 3) e_req = '0;
    end

    // reset mid-line abandons the line
    e_req = 2'b01;
    wait_gnt(0, 2'b01);
    e_req = '0;
    word(0, 0, 16'h6001, 0);
    word(0, 0, 16'h6002, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", e_gnt, 0);
    chk("arst_rp_vld", e_rv, 0);
    chk("arst_rp_din", e_rp, 0);
    chk("arst_ch", e_ch, 0);
    chk("arst_busy", e_busy, 0);
    chk("arst_done", e_ld, 0);
    e_req = 2'b10;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_gnt(0, 2'b10);
    e_req = '0;
    for (int k = 1; k <= 4; k++) word(0, 1, 16'(32'h7000 + k), k == 4);
    chk("even_ch_hold", e_ch, 1);

    // after reset, ch0 wins when both request
    @(posedge clk);
    #1 rst_n = 1'b0;
    e_req = 2'b11;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_gnt(0, 2'b01);
    e_req = '0;
    for (int k = 1; k <= 4; k++) word(0, 0, 16'(32'h8000 + k), k == 4);

    repeat (5) idle_cyc();
    chk("even_queue_empty", eq_e.size(), 0);
    chk("odd_queue_empty", eq_o.size(), 0);
    chk("even_err_pulses", e_errs, 2);
    chk("odd_err_pulses", o_errs, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
